// File: rtl/booth_mult_pkg.sv
// Shared definitions for the radix-4 Booth multiplier and its carry-lookahead adder.
package booth_mult_pkg;

  localparam int unsigned ITERATIONS = 16;
  localparam int unsigned ACC_W      = 34;
  localparam int unsigned OP_W       = 32;
  localparam int unsigned PROD_W     = ACC_W + OP_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    PA,
    P2A,
    NA,
    N2A
  } booth_sel_t;

  function automatic booth_sel_t booth_decode(input logic [2:0] trip);
    booth_sel_t sel;
    case (trip)
      3'b001, 3'b010: sel = PA;
      3'b011:         sel = P2A;
      3'b100:         sel = N2A;
      3'b101, 3'b110: sel = NA;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

  // 8-bit group-carry block: bit i of the result is the carry out of bit i,
  // each expressed directly from g/p and the group carry-in.
  function automatic logic [7:0] group_carry8(input logic [7:0] g,
                                              input logic [7:0] p,
                                              input logic       cin);
    logic [7:0] co;
    logic       pchain;
    co = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      co[i]  = g[i];
      pchain = p[i];
      for (int unsigned j = i; j > 0; j--) begin
        co[i]  = co[i] | (g[j-1] & pchain);
        pchain = pchain & p[j-1];
      end
      co[i] = co[i] | (cin & pchain);
    end
    return co;
  endfunction

endpackage

// File: rtl/cla_adder34.sv
// 34-bit carry-lookahead adder with carry-in, built from chained 8-bit group-carry blocks.
module cla_adder34
  import booth_mult_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             cin,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);

  logic [ACC_W-1:0] g;
  logic [ACC_W-1:0] p;
  logic [ACC_W:0]   c;
  logic [7:0]       gc;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    gc   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      gc              = group_carry8(g[8*k +: 8], p[8*k +: 8], c[8*k]);
      c[8*k + 1 +: 8] = gc;
    end
    // Top two bits reuse a group block with its unused upper lanes tied off.
    gc         = group_carry8({6'b0, g[33:32]}, {6'b0, p[33:32]}, c[32]);
    c[34:33]   = gc[1:0];
  end

  assign sum  = p ^ c[ACC_W-1:0];
  assign cout = c[ACC_W];

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-4 Booth multiplier: 16 iterations, low 32 product bits plus overflow.
// Optional MULT_RESTART_EN: ctrl_MULT outside IDLE aborts and restarts the operation.
module booth_mult
  import booth_mult_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            ctrl_MULT,
  input  logic [OP_W-1:0] data_operandA,
  input  logic [OP_W-1:0] data_operandB,
  output logic [OP_W-1:0] data_result,
  output logic            data_exception,
  output logic            data_resultRDY
);

  state_t            state_q, state_d;
  logic [3:0]        count_q;
  logic [OP_W-1:0]   mcand_q;
  logic [PROD_W-1:0] prod_q;
  logic              load;
  logic              finish;

  booth_sel_t        sel;
  logic [ACC_W-1:0]  addend;
  logic              sub;
  logic [ACC_W-1:0]  acc_sum;
  logic              acc_cout_unused;
  logic [PROD_W-1:0] prod_shift;
  logic              ovf;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (ctrl_MULT) begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN:  if (count_q == 4'(ITERATIONS - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MULT_RESTART_EN
    if (ctrl_MULT) begin
      load    = 1'b1;
      state_d = RUN;
    end
`endif
    finish = (state_q == DONE) && !load;
  end

  always_comb begin
    sel    = booth_decode(prod_q[2:0]);
    addend = '0;
    sub    = 1'b0;
    case (sel)
      PA:  addend = {{2{mcand_q[OP_W-1]}}, mcand_q};
      P2A: addend = {mcand_q[OP_W-1], mcand_q, 1'b0};
      NA: begin
        addend = ~{{2{mcand_q[OP_W-1]}}, mcand_q};
        sub    = 1'b1;
      end
      N2A: begin
        addend = ~{mcand_q[OP_W-1], mcand_q, 1'b0};
        sub    = 1'b1;
      end
      default: addend = '0;
    endcase
  end

  cla_adder34 u_adder (
    .a    (prod_q[PROD_W-1 -: ACC_W]),
    .b    (addend),
    .cin  (sub),
    .sum  (acc_sum),
    .cout (acc_cout_unused)
  );

  // Product sits in prod[66:1]; bits [63:31] of it must all match for no overflow.
  assign prod_shift = {{2{acc_sum[ACC_W-1]}}, acc_sum, prod_q[OP_W:2]};
  assign ovf        = !((prod_q[64:32] == '0) || (prod_q[64:32] == '1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q        <= '0;
      mcand_q        <= '0;
      prod_q         <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (load) begin
        mcand_q <= data_operandA;
        prod_q  <= {{ACC_W{1'b0}}, data_operandB, 1'b0};
        count_q <= '0;
      end else if (state_q == RUN) begin
        prod_q  <= prod_shift;
        count_q <= count_q + 4'd1;
      end else if (finish) begin
        data_result    <= prod_q[OP_W:1];
        data_exception <= ovf;
        data_resultRDY <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: signed-product reference model plus directed literals.
module tb_booth_mult;

`ifdef MULT_RESTART_EN
  localparam bit RESTART_EN = 1'b1;
`else
  localparam bit RESTART_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  booth_mult dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: accepts a start when idle (or always, with restart), completes 17 edges later.
  int unsigned cyc, due;
  bit          pend;
  logic [31:0] pend_res, exp_res;
  logic        pend_exc, exp_exc, exp_rdy;
  longint      p;

  initial begin
    pend = 0; exp_rdy = 0; exp_res = '0; exp_exc = 0; cyc = 0; due = 0;
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend = 0; exp_rdy = 0; exp_res = '0; exp_exc = 0; cyc = 0;
    end else begin
      cyc++;
      exp_rdy = 0;
      if (ctrl_MULT && (!pend || RESTART_EN)) begin
        pend     = 1;
        due      = cyc + 17;
        p        = longint'($signed(data_operandA)) * longint'($signed(data_operandB));
        pend_res = p[31:0];
        pend_exc = (p != longint'($signed(p[31:0])));
      end else if (pend && cyc == due) begin
        pend    = 0;
        exp_rdy = 1;
        exp_res = pend_res;
        exp_exc = pend_exc;
      end
    end
  end

  always @(negedge clock) begin
    chk("rdy", 64'(data_resultRDY), 64'(exp_rdy));
    chk("result", 64'(data_result), 64'(exp_res));
    chk("exception", 64'(data_exception), 64'(exp_exc));
  end

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee, input string nm);
    int lat;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat = 0;
    while (lat <= 40) begin
      @(negedge clock);
      if (data_resultRDY) break;
      @(posedge clock);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd17);
    chk({nm, "_result"}, 64'(data_result), 64'(er));
    chk({nm, "_exc"}, 64'(data_exception), 64'(ee));
    @(posedge clock);
    #1;
  endtask

  logic [31:0] corner [6];
  logic [31:0] ra, rb;
  int          first_lat, nrdy;
  logic [31:0] first_res;

  initial begin
    corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h8000_0000; corner[5] = 32'h0001_0000;

    reset = 1'b0; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
    wait_edges(3);
    chk("reset_rdy", 64'(data_resultRDY), 64'd0);
    chk("reset_result", 64'(data_result), 64'd0);
    chk("reset_exc", 64'(data_exception), 64'd0);
    reset = 1'b1;
    wait_edges(2);

    do_op(32'd7, 32'd6, 32'h0000_002A, 1'b0, "7x6");
    do_op(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, "m3x5");
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "maxxm1");
    do_op(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "2p16sq");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "minxm1");
    do_op(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "minxmin");

    // Reset mid-run: start, drop reset after edge 8, then confirm nothing completes.
    data_operandA = 32'd9; data_operandB = 32'd11; ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    wait_edges(8);
    reset = 1'b0;
    #1;
    chk("midreset_result", 64'(data_result), 64'd0);
    chk("midreset_exc", 64'(data_exception), 64'd0);
    wait_edges(2);
    reset = 1'b1;
    wait_edges(25);
    do_op(32'd9, 32'd11, 32'd99, 1'b0, "after_reset");

    // Second request at edge 5 of a running operation.
    data_operandA = 32'd7; data_operandB = 32'd6; ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    first_lat = -1; nrdy = 0; first_res = '0;
    for (int lat = 0; lat <= 45; lat++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        nrdy++;
        if (first_lat < 0) begin
          first_lat = lat;
          first_res = data_result;
        end
      end
      if (lat == 4) begin
        ctrl_MULT = 1'b1; data_operandA = 32'd2; data_operandB = 32'd3;
      end else begin
        ctrl_MULT = 1'b0;
      end
      @(posedge clock);
      #1;
    end
    chk("restart_rdy_count", 64'(nrdy), 64'd1);
    if (RESTART_EN) begin
      chk("restart_latency", 64'(first_lat), 64'd22);
      chk("restart_result", 64'(first_res), 64'd6);
    end else begin
      chk("ignore_latency", 64'(first_lat), 64'd17);
      chk("ignore_result", 64'(first_res), 64'd42);
    end

    // Back-to-back random operands, one start every 18 edges.
    for (int i = 0; i < 1000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      data_operandA = ra; data_operandB = rb; ctrl_MULT = 1'b1;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      data_operandA = $urandom; data_operandB = $urandom;
      wait_edges(17);
    end
    wait_edges(20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
